// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the pipelined ALU.
//   alu_op_e    - 4-bit opcode encodings; codes 12-15 are illegal.
//   alu_state_e - control states of alu_pipe (MUL/WAIT exist only with ALU_MUL_EN).
//   is_mul()    - true for the opcodes that use the iterative multiplier.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD   = 4'd0,
    OP_SUB   = 4'd1,
    OP_AND   = 4'd2,
    OP_OR    = 4'd3,
    OP_XOR   = 4'd4,
    OP_SHL   = 4'd5,
    OP_SHR   = 4'd6,
    OP_SRA   = 4'd7,
    OP_SLT   = 4'd8,
    OP_SLTU  = 4'd9,
    OP_MUL   = 4'd10,
    OP_MULHU = 4'd11
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    WAIT = 2'd2
  } alu_state_e;

  function automatic logic is_mul(input alu_op_e op);
    return (op == OP_MUL) || (op == OP_MULHU);
  endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// alu_mul_iter: unsigned iterative shift-add multiplier, one partial product per clk.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset (control only)
//   start     - load a/b; the partial product for b[0] is folded in at load time
//   a, b      - WIDTH-bit unsigned operands
//   busy      - steps still outstanding
//   done      - the final step happens this cycle; product already shows its result
//   product   - 2*WIDTH-bit product (post-step value while busy, held value after)
module alu_mul_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH - 1);

  logic [CW-1:0]      cnt_p1;
  logic [2*WIDTH-1:0] mcand_p1;
  logic [2*WIDTH-1:0] acc_p1;
  logic [WIDTH-1:0]   mplier_p1;
  logic [2*WIDTH-1:0] acc_step;

  assign acc_step = acc_p1 + (mplier_p1[0] ? mcand_p1 : '0);
  assign busy     = (cnt_p1 != '0);
  // cnt counts remaining steps; the last one runs while cnt==1 so the
  // product can be registered in that same cycle (total latency WIDTH).
  assign done     = (cnt_p1 == CW'(1));
  assign product  = busy ? acc_step : acc_p1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        cnt_p1 <= '0;
    else if (start) cnt_p1 <= CNT_LOAD;
    else if (busy)  cnt_p1 <= cnt_p1 - 1'b1;
  end

  // Stage p1: multiplicand / multiplier / accumulator shift registers
  always_ff @(posedge clk) begin
    if (start) begin
      mcand_p1  <= {{(WIDTH-1){1'b0}}, a, 1'b0};
      mplier_p1 <= {1'b0, b[WIDTH-1:1]};
      acc_p1    <= b[0] ? {{WIDTH{1'b0}}, a} : '0;
    end else if (busy) begin
      acc_p1    <= acc_step;
      mcand_p1  <= mcand_p1 << 1;
      mplier_p1 <= mplier_p1 >> 1;
    end
  end

endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: registered ALU with valid/ready handshakes on both sides.
// Build option: define ALU_MUL_EN to add MUL/MULHU via alu_mul_iter; without
// it those opcodes return out_err=1, out_result=0 with single-cycle latency.
// Ports:
//   clk, rst               - clock, asynchronous active-high reset
//   in_valid/in_ready      - operand beat handshake (in_a, in_b, in_op)
//   out_valid/out_ready    - result beat handshake
//   out_result             - WIDTH-bit result
//   out_carry              - ADD carry-out, SUB/SLTU borrow, else 0
//   out_zero               - out_result == 0
//   out_ovf                - ADD/SUB signed overflow, else 0
//   out_err                - illegal/disabled opcode (result forced to 0)
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [3:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_carry,
  output logic             out_zero,
  output logic             out_ovf,
  output logic             out_err
);

  localparam int SW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic                     can_out;
  logic                     idle;
  logic                     accept;
  logic                     mul_start;
  logic                     mul_fin;
  logic [WIDTH-1:0]         mul_res;
  logic signed [WIDTH-1:0]  a_s;
  logic signed [WIDTH-1:0]  b_s;
  logic [WIDTH:0]           sum_p0;
  logic [WIDTH:0]           diff_p0;
  logic [SW-1:0]            sh_p0;
  logic [WIDTH-1:0]         res_p0;
  logic                     carry_p0;
  logic                     ovf_p0;
  logic                     err_p0;

  // Signed overflow of a+b from the sign bits; subtraction passes ~b's sign.
  function automatic logic add_ovf(input logic sa, input logic sb, input logic sr);
    return (sa == sb) && (sr != sa);
  endfunction

  assign can_out  = !out_valid || out_ready;
  assign in_ready = !rst && idle && can_out;
  assign accept   = in_valid && in_ready;

  // Stage p0: single-cycle datapath
  assign a_s     = in_a;
  assign b_s     = in_b;
  assign sh_p0   = in_b[SW-1:0];
  assign sum_p0  = {1'b0, in_a} + {1'b0, in_b};
  assign diff_p0 = {1'b0, in_a} - {1'b0, in_b};

  always_comb begin
    res_p0   = '0;
    carry_p0 = 1'b0;
    ovf_p0   = 1'b0;
    err_p0   = 1'b0;
    case (alu_op_e'(in_op))
      OP_ADD: begin
        res_p0   = sum_p0[WIDTH-1:0];
        carry_p0 = sum_p0[WIDTH];
        ovf_p0   = add_ovf(in_a[WIDTH-1], in_b[WIDTH-1], sum_p0[WIDTH-1]);
      end
      OP_SUB: begin
        res_p0   = diff_p0[WIDTH-1:0];
        carry_p0 = diff_p0[WIDTH];
        ovf_p0   = add_ovf(in_a[WIDTH-1], ~in_b[WIDTH-1], diff_p0[WIDTH-1]);
      end
      OP_AND:  res_p0 = in_a & in_b;
      OP_OR:   res_p0 = in_a | in_b;
      OP_XOR:  res_p0 = in_a ^ in_b;
      OP_SHL:  res_p0 = in_a << sh_p0;
      OP_SHR:  res_p0 = in_a >> sh_p0;
      OP_SRA:  res_p0 = a_s >>> sh_p0;
      OP_SLT:  res_p0 = (a_s < b_s) ? ONE : '0;
      OP_SLTU: begin
        res_p0   = diff_p0[WIDTH] ? ONE : '0;
        carry_p0 = diff_p0[WIDTH];
      end
      default: err_p0 = 1'b1;
    endcase
  end

`ifdef ALU_MUL_EN
  alu_state_e         state;
  logic               mul_busy;
  logic               mul_done;
  logic               mul_hi_p1;
  logic [2*WIDTH-1:0] mul_prod;

  assign mul_start = accept && is_mul(alu_op_e'(in_op));
  assign idle      = (state == IDLE) && !mul_busy;
  assign mul_fin   = can_out && (((state == MUL) && mul_done) || (state == WAIT));
  assign mul_res   = mul_hi_p1 ? mul_prod[2*WIDTH-1:WIDTH] : mul_prod[WIDTH-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    if (mul_start) state <= MUL;
        MUL:     if (mul_done)  state <= can_out ? IDLE : WAIT;
        WAIT:    if (can_out)   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (mul_start) mul_hi_p1 <= (in_op == OP_MULHU);
  end

  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .a       (in_a),
    .b       (in_b),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_prod)
  );
`else
  assign idle      = 1'b1;
  assign mul_start = 1'b0;
  assign mul_fin   = 1'b0;
  assign mul_res   = '0;
`endif

  // Stage p1: output register; a new result replaces one accepted this same clk
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_result <= '0;
      out_carry  <= 1'b0;
      out_zero   <= 1'b0;
      out_ovf    <= 1'b0;
      out_err    <= 1'b0;
    end else if (accept && !mul_start) begin
      out_valid  <= 1'b1;
      out_result <= res_p0;
      out_carry  <= carry_p0;
      out_zero   <= (res_p0 == '0);
      out_ovf    <= ovf_p0;
      out_err    <= err_p0;
    end else if (mul_fin) begin
      out_valid  <= 1'b1;
      out_result <= mul_res;
      out_carry  <= 1'b0;
      out_zero   <= (mul_res == '0);
      out_ovf    <= 1'b0;
      out_err    <= 1'b0;
    end else if (out_ready) begin
      out_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: scoreboard bench for alu_pipe (WIDTH=8). The driver pushes the
// expected response of every accepted beat; the monitor pops and compares on
// each output transfer. Define ALU_MUL_EN to exercise the multiplier build.
`timescale 1ns/1ps
module tb_alu_pipe;

  localparam int W = 8;
  localparam logic [3:0] ADD = 4'd0, SUB = 4'd1, AND_ = 4'd2, OR_ = 4'd3, XOR_ = 4'd4;
  localparam logic [3:0] SHL = 4'd5, SHR = 4'd6, SRA = 4'd7, SLT = 4'd8, SLTU = 4'd9;
  localparam logic [3:0] MULL = 4'd10, MULHU = 4'd11;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b1;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic [3:0]   in_op = '0;
  logic         in_ready, out_valid, out_carry, out_zero, out_ovf, out_err;
  logic [W-1:0] out_result;

  alu_pipe #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .out_valid(out_valid),
    .out_ready(out_ready), .out_result(out_result), .out_carry(out_carry),
    .out_zero(out_zero), .out_ovf(out_ovf), .out_err(out_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] r;
    logic c, z, o, e;
    string name;
  } exp_t;

  exp_t q[$];
  int n_tests = 0;
  int n_fail  = 0;

  function automatic exp_t mk(input logic [W-1:0] r, input logic c, input logic o,
                              input logic e, input string name);
    exp_t x;
    x.r = r; x.c = c; x.z = (r == '0); x.o = o; x.e = e; x.name = name;
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Monitor: every output transfer must match the oldest expected beat.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && out_valid && out_ready) begin
      n_tests++;
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_beat: got r=%0h with no beat expected", out_result);
      end else begin
        e = q.pop_front();
        if ({out_result, out_carry, out_zero, out_ovf, out_err} !== {e.r, e.c, e.z, e.o, e.e}) begin
          n_fail++;
          $display("FAIL %s: got r=%0h c=%0b z=%0b o=%0b e=%0b expected r=%0h c=%0b z=%0b o=%0b e=%0b",
                   e.name, out_result, out_carry, out_zero, out_ovf, out_err,
                   e.r, e.c, e.z, e.o, e.e);
        end
      end
    end
  end

  // Drive one beat, hold it until accepted, then return #1 after the accept edge.
  task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input exp_t e, input bit push);
    int n;
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b;
    n = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 50) begin
        n_tests++; n_fail++;
        $display("FAIL %s_accept: in_ready stuck low, expected acceptance within 50 clk", e.name);
        in_valid = 1'b0;
        return;
      end
    end
    if (push) q.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                      input exp_t e);
    issue(op, a, b, e, 1'b1);
  endtask

  // Edges until out_valid, counting the accept edge as 1; also counts cycles
  // in which in_ready was seen high while waiting.
  task automatic latency(input string name, input int exp_lat, output int ready_hi);
    int lat;
    lat = 1; ready_hi = 0;
    while (!out_valid && lat < 40) begin
      if (in_ready) ready_hi++;
      @(posedge clk); #1;
      lat++;
    end
    chk(name, lat, exp_lat);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((q.size() != 0 || out_valid) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) begin
      n_tests++; n_fail++;
      $display("FAIL drain: %0d beats outstanding, expected 0", q.size());
    end
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $display("[TB] %0d tests run, %0d failed", n_tests + 1, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] bvals [16];
    logic [W:0]   s;
    time          t0;
    int           rh;

    bvals = '{8'h00, 8'h01, 8'h02, 8'h0F, 8'h10, 8'h37, 8'h55, 8'h7E,
              8'h7F, 8'h80, 8'h81, 8'hAA, 8'hC3, 8'hF0, 8'hFE, 8'hFF};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_result", out_result, 0);
    chk("rst_flags", {out_carry, out_zero, out_ovf, out_err}, 0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    chk("idle_in_ready", in_ready, 1);

    // Directed vectors
    send(ADD,  8'd200, 8'd100, mk(8'd44,  1, 0, 0, "add_200_100"));
    send(ADD,  8'd127, 8'd1,   mk(8'd128, 0, 1, 0, "add_127_1"));
    send(SUB,  8'd5,   8'd7,   mk(8'd254, 1, 0, 0, "sub_5_7"));
    send(SUB,  8'd9,   8'd9,   mk(8'd0,   0, 0, 0, "sub_9_9"));
    send(SUB,  8'h80,  8'h01,  mk(8'h7F,  0, 1, 0, "sub_ovf"));
    send(SRA,  8'h80,  8'd3,   mk(8'hF0,  0, 0, 0, "sra_80_3"));
    send(SLT,  8'hFF,  8'd1,   mk(8'd1,   0, 0, 0, "slt_ff_1"));
    send(SLT,  8'd1,   8'hFF,  mk(8'd0,   0, 0, 0, "slt_1_ff"));
    send(SLTU, 8'hFF,  8'd1,   mk(8'd0,   0, 0, 0, "sltu_ff_1"));
    send(SLTU, 8'd1,   8'hFF,  mk(8'd1,   1, 0, 0, "sltu_1_ff"));
    send(AND_, 8'hF0,  8'h3C,  mk(8'h30,  0, 0, 0, "and"));
    send(OR_,  8'hF0,  8'h0F,  mk(8'hFF,  0, 0, 0, "or"));
    send(XOR_, 8'hAA,  8'hFF,  mk(8'h55,  0, 0, 0, "xor"));
    send(SHL,  8'h81,  8'd1,   mk(8'h02,  0, 0, 0, "shl_1"));
    send(SHL,  8'h81,  8'd9,   mk(8'h02,  0, 0, 0, "shl_amount_wraps"));
    send(SHR,  8'h81,  8'd4,   mk(8'h08,  0, 0, 0, "shr_4"));
    wait_drain();

    send(ADD, 8'd1, 8'd2, mk(8'd3, 0, 0, 0, "lat_add_beat"));
    latency("lat_add", 1, rh);
    wait_drain();

    // ADD sweep: one result per clk with out_ready held high
    t0 = $time;
    for (int a = 0; a < 256; a++) begin
      for (int j = 0; j < 16; j++) begin
        s = {1'b0, W'(a)} + {1'b0, bvals[j]};
        send(ADD, W'(a), bvals[j],
             mk(s[W-1:0], s[W], (a[7] == bvals[j][7]) && (s[7] != a[7]), 0, "add_sweep"));
      end
    end
    chk("sweep_rate_clks", 32'((($time - t0) / 10)), 4096);
    wait_drain();

    // Backpressure: result held, then drained and replaced in one clk
    out_ready = 1'b0;
    send(ADD, 8'd3, 8'd4, mk(8'd7, 0, 0, 0, "bp_first"));
    for (int k = 0; k < 5; k++) begin
      chk("bp_hold", {out_valid, in_ready, out_result}, {1'b1, 1'b0, 8'd7});
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    t0 = $time;
    send(ADD, 8'd10, 8'd20, mk(8'd30, 0, 0, 0, "bp_second"));
    chk("bp_same_clk", 32'((($time - t0) / 10)), 1);
    chk("bp_replace", {out_valid, out_result}, {1'b1, 8'd30});
    wait_drain();

`ifdef ALU_MUL_EN
    send(MULL, 8'd15, 8'd17, mk(8'd255, 0, 0, 0, "mul_15_17"));
    latency("lat_mul", 8, rh);
    chk("mul_in_ready_low", rh, 0);
    wait_drain();
    send(MULHU, 8'd200, 8'd200, mk(8'h9C, 0, 0, 0, "mulhu_200_200"));
    latency("lat_mulhu", 8, rh);
    wait_drain();
    send(MULL,  8'hFF, 8'hFF, mk(8'h01, 0, 0, 0, "mul_ff_ff"));
    wait_drain();
    send(MULHU, 8'hFF, 8'hFF, mk(8'hFE, 0, 0, 0, "mulhu_ff_ff"));
    wait_drain();

    out_ready = 1'b0;
    send(MULL, 8'd12, 8'd12, mk(8'd144, 0, 0, 0, "mul_backpressure"));
    repeat (14) begin @(posedge clk); #1; end
    chk("mul_held", {out_valid, in_ready, out_result}, {1'b1, 1'b0, 8'd144});
    out_ready = 1'b1;
    wait_drain();

    // Reset during the 4th multiply cycle discards the operation
    issue(MULL, 8'd7, 8'd7, mk(8'd49, 0, 0, 0, "mul_discarded"), 1'b0);
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1; #1;
    chk("rst_mid_mul", {out_valid, in_ready}, 0);
`else
    out_ready = 1'b0;
    issue(ADD, 8'd5, 8'd5, mk(8'd10, 0, 0, 0, "add_discarded"), 1'b0);
    rst = 1'b1; #1;
    chk("rst_held_result", {out_valid, in_ready}, 0);
    out_ready = 1'b1;
`endif
    @(posedge clk); @(negedge clk); rst = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    chk("after_rst_no_beat", out_valid, 0);
    send(ADD, 8'd1, 8'd1, mk(8'd2, 0, 0, 0, "add_after_rst"));
    latency("lat_after_rst", 1, rh);
    wait_drain();

`ifndef ALU_MUL_EN
    send(MULL, 8'd3, 8'd3, mk(8'd0, 0, 0, 1, "mul_disabled"));
    latency("lat_mul_disabled", 1, rh);
    wait_drain();
`endif
    send(4'd14, 8'h12, 8'h34, mk(8'd0, 0, 0, 1, "illegal_14"));
    latency("lat_illegal", 1, rh);
    send(4'd12, 8'hFF, 8'hFF, mk(8'd0, 0, 0, 1, "illegal_12"));
    send(4'd15, 8'h01, 8'h01, mk(8'd0, 0, 0, 1, "illegal_15"));
    wait_drain();

    chk("scoreboard_empty", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
